// File: rtl/int_sequencer_pkg.sv
// Shared constants for the interrupt sequencer: service-type bit positions,
// vector low bytes, and controller state encodings.
package int_sequencer_pkg;

    // Bit positions inside the one-hot int_array.
    localparam logic [1:0] RST_I = 2'd0;
    localparam logic [1:0] NMI_I = 2'd1;
    localparam logic [1:0] IRQ_I = 2'd2;
    localparam logic [1:0] BRK_I = 2'd3;

    // Vector low bytes; the high byte is always FF.
    localparam logic [7:0] VEC_RST = 8'hFC;
    localparam logic [7:0] VEC_NMI = 8'hFA;
    localparam logic [7:0] VEC_IRQ = 8'hFE;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_SERVICE = 2'd1,
        ST_LOCKED  = 2'd2
    } state_t;

    // One-hot service-type word with only the bit at idx set.
    function automatic logic [3:0] int_onehot(input logic [1:0] idx);
        logic [3:0] r;
        r      = 4'b0000;
        r[idx] = 1'b1;
        return r;
    endfunction

endpackage

// File: rtl/int_sequencer_nmi_edge_sync.sv
// NMI input synchronizer, rising-edge detector and pending latch.
// Runs regardless of RDY so that an NMI edge during a stall is never lost.
module nmi_edge_sync #(
    parameter int NMI_SYNC = 2
) (
    input  logic phi1,
    input  logic rst,
    input  logic nmi_in,
    input  logic clr,
    output logic nmi_pend
);

    logic [NMI_SYNC-1:0] sync_reg;
    logic [NMI_SYNC-1:0] sync_next;
    logic                prev_reg;
    logic                pend_reg;
    logic                pend_next;
    logic                nmi_edge;

    // Synchronizer shift path: stage 0 samples the pin, each later stage
    // samples the one before it.
    assign sync_next[0] = nmi_in;
    generate
        for (genvar gi = 1; gi < NMI_SYNC; gi++) begin : g_sync
            assign sync_next[gi] = sync_reg[gi-1];
        end
    endgenerate

    // Edge detection on the synchronized level; a held-high input only fires once.
    assign nmi_edge = sync_reg[NMI_SYNC-1] & ~prev_reg;

    // A new edge wins over a clear on the same edge so it is never dropped.
    assign pend_next = nmi_edge | (pend_reg & ~clr);

    // Synchronizer, edge history and pending latch registers.
    always_ff @(posedge phi1) begin
        if (rst) begin
            sync_reg <= '0;
            prev_reg <= 1'b0;
            pend_reg <= 1'b0;
        end else begin
            sync_reg <= sync_next;
            prev_reg <= sync_reg[NMI_SYNC-1];
            pend_reg <= pend_next;
        end
    end

    assign nmi_pend = pend_reg;

endmodule

// File: rtl/int_sequencer.sv
// Interrupt sequencer: arbitrates RST/NMI/IRQ/BRK at instruction boundaries,
// tracks the service sequence, and supplies the vector low byte.
module int_sequencer
    import int_sequencer_pkg::*;
#(
    parameter int NMI_SYNC = 2
) (
    input  logic       phi1,
    input  logic       rst,
    input  logic       nmi_in,
    input  logic       irq_in,
    input  logic       i_flag,
    input  logic       brk_op,
    input  logic       sync_in,
    input  logic       rdy,
    input  logic       vec_fetch,
    input  logic       svc_done,
    output logic [3:0] int_array,
    output logic       int_active,
    output logic [7:0] vec_lo,
    output logic       nmi_pend
);

    state_t     state_reg,      state_next;
    logic [3:0] int_array_reg,  int_array_next;
    logic       int_active_reg, int_active_next;
    logic [7:0] vec_lo_reg,     vec_lo_next;
    logic       rst_req_reg,    rst_req_next;
    logic       nmi_clr;
    logic       irq_req;
    logic       any_req;
    logic       hijack;

    nmi_edge_sync #(
        .NMI_SYNC (NMI_SYNC)
    ) u_nmi (
        .phi1     (phi1),
        .rst      (rst),
        .nmi_in   (nmi_in),
        .clr      (nmi_clr),
        .nmi_pend (nmi_pend)
    );

    assign irq_req = irq_in & ~i_flag;
    assign any_req = nmi_pend | irq_req | brk_op;
    assign hijack  = nmi_pend & (int_array_reg[IRQ_I] | int_array_reg[BRK_I]);

    // Controller state and registered outputs; reset starts the RST service.
    always_ff @(posedge phi1) begin
        if (rst) begin
            state_reg      <= ST_IDLE;
            int_array_reg  <= int_onehot(RST_I);
            int_active_reg <= 1'b1;
            vec_lo_reg     <= VEC_RST;
            rst_req_reg    <= 1'b1;
        end else begin
            state_reg      <= state_next;
            int_array_reg  <= int_array_next;
            int_active_reg <= int_active_next;
            vec_lo_reg     <= vec_lo_next;
            rst_req_reg    <= rst_req_next;
        end
    end

    // Next-state logic: arbitration, NMI hijack and service completion.
    // With RDY low everything holds; the NMI latch keeps running on its own.
    always_comb begin
        state_next      = state_reg;
        int_array_next  = int_array_reg;
        int_active_next = int_active_reg;
        vec_lo_next     = vec_lo_reg;
        rst_req_next    = rst_req_reg;
        nmi_clr         = 1'b0;

        if (rdy) begin
            unique case (state_reg)
                ST_IDLE: begin
                    if (rst_req_reg) begin
                        // The reset sequence is already underway when reset
                        // releases, so it is taken without waiting for SYNC.
                        state_next      = ST_SERVICE;
                        int_array_next  = int_onehot(RST_I);
                        int_active_next = 1'b1;
                        vec_lo_next     = VEC_RST;
                        rst_req_next    = 1'b0;
                    end else if (sync_in && any_req) begin
                        state_next      = ST_SERVICE;
                        int_active_next = 1'b1;
                        if (nmi_pend) begin
                            int_array_next = int_onehot(NMI_I);
                            vec_lo_next    = VEC_NMI;
                            nmi_clr        = 1'b1;
                        end else if (irq_req) begin
                            int_array_next = int_onehot(IRQ_I);
                            vec_lo_next    = VEC_IRQ;
                        end else begin
                            int_array_next = int_onehot(BRK_I);
                            vec_lo_next    = VEC_IRQ;
                        end
                    end
                end
                ST_SERVICE: begin
                    if (svc_done) begin
                        state_next      = ST_IDLE;
                        int_array_next  = 4'b0000;
                        int_active_next = 1'b0;
                        vec_lo_next     = VEC_IRQ;
                    end else begin
                        if (vec_fetch) begin
                            state_next = ST_LOCKED;
                        end
                        // NMI may steal an IRQ/BRK sequence up to the vector fetch.
                        if (hijack) begin
                            int_array_next = int_onehot(NMI_I);
                            vec_lo_next    = VEC_NMI;
                            nmi_clr        = 1'b1;
                        end
                    end
                end
                ST_LOCKED: begin
                    if (svc_done) begin
                        state_next      = ST_IDLE;
                        int_array_next  = 4'b0000;
                        int_active_next = 1'b0;
                        vec_lo_next     = VEC_IRQ;
                    end
                end
                default: begin
                    state_next = ST_IDLE;
                end
            endcase
        end
    end

    assign int_array  = int_array_reg;
    assign int_active = int_active_reg;
    assign vec_lo     = vec_lo_reg;

endmodule

// File: tb/tb_int_sequencer.sv
// Self-checking bench for int_sequencer: expected service results are queued
// when a request is driven and compared once the DUT presents the service.
module tb_int_sequencer;

    logic       phi1 = 1'b0;
    logic       rst, nmi_in, irq_in, i_flag, brk_op, sync_in, rdy, vec_fetch, svc_done;
    logic [3:0] int_array;
    logic       int_active;
    logic [7:0] vec_lo;
    logic       nmi_pend;

    typedef struct {
        string      tag;
        logic [3:0] arr;
        logic [7:0] vec;
    } exp_t;

    exp_t exp_q[$];
    int   checks   = 0;
    int   failures = 0;

    int_sequencer #(.NMI_SYNC(2)) dut (
        .phi1       (phi1),
        .rst        (rst),
        .nmi_in     (nmi_in),
        .irq_in     (irq_in),
        .i_flag     (i_flag),
        .brk_op     (brk_op),
        .sync_in    (sync_in),
        .rdy        (rdy),
        .vec_fetch  (vec_fetch),
        .svc_done   (svc_done),
        .int_array  (int_array),
        .int_active (int_active),
        .vec_lo     (vec_lo),
        .nmi_pend   (nmi_pend)
    );

    always #5 phi1 = ~phi1;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // One rising edge, then settle 1 time unit before driving or sampling.
    task automatic tick();
        @(posedge phi1);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic sb_push(input string tag, input logic [3:0] arr, input logic [7:0] vec);
        exp_t e;
        e.tag = tag;
        e.arr = arr;
        e.vec = vec;
        exp_q.push_back(e);
    endtask

    // Wait (bounded) for an active service, then compare against the queue head.
    task automatic sb_pop_check();
        exp_t e;
        int   n;
        n = 0;
        while (!int_active && n < 8) begin
            tick();
            n++;
        end
        if (exp_q.size() == 0) begin
            check_eq("sb_empty", 32'd1, 32'd0);
            return;
        end
        e = exp_q.pop_front();
        check_eq({e.tag, "_active"}, {31'd0, int_active}, 32'd1);
        check_eq({e.tag, "_array"}, {28'd0, int_array}, {28'd0, e.arr});
        check_eq({e.tag, "_vec"}, {24'd0, vec_lo}, {24'd0, e.vec});
        $display("txn %s: int_array=%b vec_lo=%h nmi_pend=%b", e.tag, int_array, vec_lo, nmi_pend);
    endtask

    task automatic sync_pulse();
        sync_in = 1'b1;
        tick();
        sync_in = 1'b0;
    endtask

    task automatic vec_fetch_pulse();
        vec_fetch = 1'b1;
        tick();
        vec_fetch = 1'b0;
    endtask

    task automatic svc_end(input string tag);
        svc_done = 1'b1;
        tick();
        svc_done = 1'b0;
        check_eq({tag, "_end_active"}, {31'd0, int_active}, 32'd0);
        check_eq({tag, "_end_array"}, {28'd0, int_array}, 32'd0);
        check_eq({tag, "_end_vec"}, {24'd0, vec_lo}, 32'hFE);
        $display("txn %s_end: int_array=%b vec_lo=%h", tag, int_array, vec_lo);
    endtask

    // Clean NMI pulse: high for two samples, then low; pending latch and any
    // hijack have settled by the end.
    task automatic nmi_pulse();
        nmi_in = 1'b1;
        ticks(2);
        nmi_in = 1'b0;
        ticks(3);
    endtask

    initial begin
        rst = 1'b1; nmi_in = 1'b0; irq_in = 1'b0; i_flag = 1'b0; brk_op = 1'b0;
        sync_in = 1'b0; rdy = 1'b1; vec_fetch = 1'b0; svc_done = 1'b0;

        // Reset state and RST service completion.
        ticks(2);
        check_eq("rst_array", {28'd0, int_array}, 32'h1);
        check_eq("rst_active", {31'd0, int_active}, 32'd1);
        check_eq("rst_vec", {24'd0, vec_lo}, 32'hFC);
        check_eq("rst_pend", {31'd0, nmi_pend}, 32'd0);
        rst = 1'b0;
        sb_push("rst_svc", 4'b0001, 8'hFC);
        tick();
        sb_pop_check();
        tick();
        check_eq("rst_hold_array", {28'd0, int_array}, 32'h1);
        svc_end("rst");

        // NMI latency: sampled high at edge k, pending after edge k+2.
        nmi_in = 1'b1;
        tick();
        tick();
        check_eq("nmi_lat_k1", {31'd0, nmi_pend}, 32'd0);
        tick();
        check_eq("nmi_lat_k2", {31'd0, nmi_pend}, 32'd1);
        sb_push("nmi", 4'b0010, 8'hFA);
        sync_pulse();
        sb_pop_check();
        check_eq("nmi_clr", {31'd0, nmi_pend}, 32'd0);
        ticks(4);
        check_eq("nmi_hold_no_retrig", {31'd0, nmi_pend}, 32'd0);
        nmi_in = 1'b0;
        svc_end("nmi");

        // Masked IRQ is ignored; unmasking lets the next boundary accept it.
        irq_in = 1'b1; i_flag = 1'b1;
        sync_pulse();
        check_eq("mask1_active", {31'd0, int_active}, 32'd0);
        sync_pulse();
        check_eq("mask2_active", {31'd0, int_active}, 32'd0);
        i_flag = 1'b0;
        sb_push("irq", 4'b0100, 8'hFE);
        sync_pulse();
        sb_pop_check();
        irq_in = 1'b0;
        vec_fetch_pulse();
        svc_end("irq");

        // IRQ that drops before a boundary is lost.
        irq_in = 1'b1;
        tick();
        irq_in = 1'b0;
        sync_pulse();
        check_eq("irq_lost_active", {31'd0, int_active}, 32'd0);

        // Priority: NMI beats IRQ and BRK; IRQ follows on the next boundary.
        nmi_pulse();
        check_eq("prio_pend", {31'd0, nmi_pend}, 32'd1);
        irq_in = 1'b1; brk_op = 1'b1;
        sb_push("prio_nmi", 4'b0010, 8'hFA);
        sync_pulse();
        brk_op = 1'b0;
        sb_pop_check();
        svc_end("prio_nmi");
        sb_push("prio_irq", 4'b0100, 8'hFE);
        sync_pulse();
        sb_pop_check();

        // Hijack of the IRQ service before the vector fetch.
        irq_in = 1'b0;
        nmi_pulse();
        sb_push("hijack_irq", 4'b0010, 8'hFA);
        sb_pop_check();
        check_eq("hijack_pend", {31'd0, nmi_pend}, 32'd0);
        vec_fetch_pulse();
        svc_end("hijack_irq");

        // NMI after the vector fetch: vector stays, NMI stays pending.
        irq_in = 1'b1;
        sb_push("late_irq", 4'b0100, 8'hFE);
        sync_pulse();
        sb_pop_check();
        irq_in = 1'b0;
        vec_fetch_pulse();
        nmi_pulse();
        check_eq("late_array", {28'd0, int_array}, 32'h4);
        check_eq("late_vec", {24'd0, vec_lo}, 32'hFE);
        check_eq("late_pend", {31'd0, nmi_pend}, 32'd1);
        svc_end("late_irq");
        sb_push("late_nmi", 4'b0010, 8'hFA);
        sync_pulse();
        sb_pop_check();
        svc_end("late_nmi");

        // BRK hijacked by NMI: the BRK bit is dropped.
        brk_op = 1'b1;
        sb_push("brk", 4'b1000, 8'hFE);
        sync_pulse();
        brk_op = 1'b0;
        sb_pop_check();
        nmi_pulse();
        sb_push("hijack_brk", 4'b0010, 8'hFA);
        sb_pop_check();
        svc_end("hijack_brk");

        // RDY stall: svc_done ignored, NMI still latched, hijack after release.
        brk_op = 1'b1;
        sb_push("stall_brk", 4'b1000, 8'hFE);
        sync_pulse();
        brk_op = 1'b0;
        sb_pop_check();
        rdy = 1'b0;
        svc_done = 1'b1;
        tick();
        svc_done = 1'b0;
        check_eq("stall_active", {31'd0, int_active}, 32'd1);
        nmi_pulse();
        check_eq("stall_pend", {31'd0, nmi_pend}, 32'd1);
        check_eq("stall_array", {28'd0, int_array}, 32'h8);
        rdy = 1'b1;
        tick();
        sb_push("stall_hijack", 4'b0010, 8'hFA);
        sb_pop_check();
        svc_end("stall");

        // Reset mid-service discards a pending NMI and restarts the RST service.
        brk_op = 1'b1;
        sb_push("abort_brk", 4'b1000, 8'hFE);
        sync_pulse();
        brk_op = 1'b0;
        sb_pop_check();
        vec_fetch_pulse();
        nmi_pulse();
        check_eq("abort_pre_pend", {31'd0, nmi_pend}, 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_eq("abort_pend", {31'd0, nmi_pend}, 32'd0);
        sb_push("abort_rst", 4'b0001, 8'hFC);
        sb_pop_check();
        tick();
        svc_end("abort_rst");

        check_eq("sb_drained", exp_q.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Global time bound so the run always terminates.
    initial begin
        #200000;
        $display("FAIL timeout: got=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
